// File: rtl/fetch_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_mem_pkg
// Brief    : Shared widths, word/address types and fetch-engine states.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_mem_pkg;

    localparam int ADDR_LEN = 11;
    localparam int DEPTH    = 2 ** ADDR_LEN;
    localparam int DATA_LEN = 40;

    typedef logic [DATA_LEN-1:0] word_t;
    typedef logic [ADDR_LEN-1:0] addr_t;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module   : word_ram
// Brief    : Single-port word RAM with registered, read-before-write output.
// Revision : 1.0 - initial release
// ============================================================================
module word_ram
    import fetch_mem_pkg::*;
(
    input  logic  clk,
    input  logic  rd,
    input  logic  wr,
    input  addr_t addr,
    input  word_t data_in,
    output word_t data_out
);

    word_t r_mem [DEPTH];
    word_t r_data_out;

    // Both ports sample the array before this edge's write lands, so a
    // same-address read/write returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[addr] <= data_in;
        end
        if (rd) begin
            r_data_out <= r_mem[addr];
        end
    end

    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: rtl/fetch_mem_subsys.sv
`default_nettype none
// ============================================================================
// Module   : fetch_mem_subsys
// Brief    : Program RAM plus a fetch engine that parses a header word and
//            accumulates the following payload words as they are read back.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_mem_subsys
    import fetch_mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rd,
    input  logic  wr,
    input  addr_t addr,
    input  word_t data_in,
    output word_t data_out,
    output word_t result,
    output logic  computation_end
);

    logic         r_rd_q;
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    addr_t        r_cnt;
    addr_t        w_cnt_nxt;
    addr_t        r_len;
    addr_t        w_len_nxt;
    word_t        r_result;
    word_t        w_result_nxt;

    word_ram u_word_ram (
        .clk      (clk),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q   <= 1'b0;
            r_state  <= HDR;
            r_cnt    <= '0;
            r_len    <= '0;
            r_result <= '0;
        end else begin
            r_rd_q   <= rd;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_result_nxt = r_result;
        case (r_state)
            HDR: begin
                if (r_rd_q) begin
                    w_len_nxt    = data_out[ADDR_LEN-1:0];
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_state_nxt  = (data_out[ADDR_LEN-1:0] == '0) ? DONE : PAY;
                end
            end
            PAY: begin
                if (r_rd_q) begin
                    // Wrap-around sum: carry out of the top bit is discarded.
                    w_result_nxt = r_result + data_out;
                    w_cnt_nxt    = r_cnt + addr_t'(1);
                    if (r_cnt == r_len - addr_t'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                w_state_nxt = HDR;
            end
        endcase
    end

    assign result          = r_result;
    assign computation_end = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_subsys.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_mem_subsys
// Brief    : Self-checking bench: directed cases plus randomized programs,
//            compared against a stream-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_subsys;
    import fetch_mem_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  rd;
    logic  wr;
    addr_t addr;
    word_t data_in;
    word_t data_out;
    word_t result;
    logic  computation_end;

    word_t mem_m [DEPTH];
    word_t stream [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    fetch_mem_subsys dut (
        .clk             (clk),
        .rst             (rst),
        .rd              (rd),
        .wr              (wr),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .result          (result),
        .computation_end (computation_end)
    );

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outputs once the first n words of the stream have been consumed.
    function automatic void model(input int n, output word_t res, output bit done);
        int len;
        res  = '0;
        done = 1'b0;
        if (n > 0) begin
            len = int'(stream[0][ADDR_LEN-1:0]);
            for (int i = 1; i < n && i <= len; i++) res = res + stream[i];
            done = ((n - 1) >= len);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        tick();
        rst = 1'b0;
        stream.delete();
    endtask

    task automatic write_word(input addr_t a, input word_t d);
        wr = 1'b1; rd = 1'b0; addr = a; data_in = d;
        tick();
        wr = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_outputs(input string tag, input int n);
        word_t res;
        bit    done;
        model(n, res, done);
        check({tag, "_result"}, result, res);
        check({tag, "_end"}, word_t'(computation_end), word_t'(done));
    endtask

    task automatic do_read(input addr_t a, input bit also_wr, input word_t d);
        word_t exp;
        exp = mem_m[a];
        rd = 1'b1; wr = also_wr; addr = a; data_in = d;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("data_out", data_out, exp);
        if (also_wr) mem_m[a] = d;
        check_outputs("mid", stream.size());
        stream.push_back(exp);
    endtask

    initial begin
        word_t w;
        int    len, base, nrd;

        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        do_reset();
        check_outputs("reset", 0);

        // N=3, payload 1,2,3
        write_word(0, 40'd3); write_word(1, 40'd1); write_word(2, 40'd2); write_word(3, 40'd3);
        do_reset();
        for (int i = 0; i < 4; i++) do_read(addr_t'(i), 1'b0, '0);
        idle(1);
        check("n3_result", result, 40'd6);
        check("n3_end", word_t'(computation_end), 40'd1);

        // N=0: header only
        write_word(0, 40'h12_3450_0000);
        do_reset();
        do_read(0, 1'b0, '0);
        idle(1);
        check("n0_result", result, 40'd0);
        check("n0_end", word_t'(computation_end), 40'd1);

        // wrap-around sum
        write_word(0, 40'd2); write_word(1, 40'hFF_FFFF_FFFF); write_word(2, 40'd2);
        do_reset();
        for (int i = 0; i < 3; i++) do_read(addr_t'(i), 1'b0, '0);
        idle(1);
        check("wrap_result", result, 40'd1);
        check("wrap_end", word_t'(computation_end), 40'd1);

        // truncated stream stays in payload phase
        write_word(0, 40'd4); write_word(1, 40'd10); write_word(2, 40'd20); write_word(3, 40'd30);
        do_reset();
        for (int i = 0; i < 4; i++) do_read(addr_t'(i), 1'b0, '0);
        idle(50);
        check("trunc_result", result, 40'd60);
        check("trunc_end", word_t'(computation_end), 40'd0);

        // same-cycle read/write returns old contents
        write_word(5, 40'hA);
        do_reset();
        do_read(5, 1'b1, 40'hB);
        check("rdwr_old", data_out, 40'hA);
        do_read(5, 1'b0, '0);
        check("rdwr_new", data_out, 40'hB);

        // reset mid-stream, then restream a fresh program
        write_word(0, 40'd5);
        for (int i = 1; i <= 5; i++) write_word(addr_t'(i), word_t'(i * 100));
        write_word(10, 40'd1); write_word(11, 40'd7);
        do_reset();
        for (int i = 0; i < 3; i++) do_read(addr_t'(i), 1'b0, '0);
        do_reset();
        check_outputs("midrst", 0);
        do_read(10, 1'b0, '0);
        do_read(11, 1'b0, '0);
        idle(1);
        check("restream_result", result, 40'd7);
        check("restream_end", word_t'(computation_end), 40'd1);

        // randomized programs with gaps, truncation and over-reads
        for (int t = 0; t < 40; t++) begin
            len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            base = int'($urandom_range(0, 2000));
            w = {8'($urandom), 32'($urandom)};
            w[ADDR_LEN-1:0] = addr_t'(len);
            write_word(addr_t'(base), w);
            for (int i = 1; i <= len + 2; i++) begin
                w = ($urandom_range(0, 4) == 0) ? 40'hFF_FFFF_FFFF : {8'($urandom), 32'($urandom)};
                write_word(addr_t'(base + i), w);
            end
            do_reset();
            nrd = int'($urandom_range(1, len + 3));
            for (int i = 0; i < nrd; i++) begin
                do_read(addr_t'(base + i), 1'b0, '0);
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            end
            idle(2);
            check_outputs("rand", stream.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
